echo_tx_queue: RTL and testbench
================================

Name: echo_tx_queue

Overview:
Byte queue between the effect-select mux and the UART transmitter, inserted in the echo path. It accepts processed bytes (clipping, bitcrusher or raw) as they are produced and drains them one at a time to uart_top's TX interface. Received bytes are no longer discarded while TX is busy. Overflow is counted and flagged for debug.

Parameters:
DEPTH, 16, queue depth in bytes; power of two, minimum 2
START_TIMEOUT, 64, clocks to wait for i_tx_active after o_tx_dv before aborting the launch
GAP_CYCLES, 0, idle clocks enforced after each i_tx_done before the next launch

Ports:
clk_50mhz  in  1  system clock, 50 MHz
reset_n_internal  in  1  reset, asynchronous, active-low
i_wr_dv  in  1  one-cycle strobe: push i_wr_byte
i_wr_byte  in  8  data byte to queue (filter_select)
i_tx_active  in  1  UART TX busy
i_tx_done  in  1  UART TX one-cycle done pulse
o_tx_dv  out  1  one-cycle launch strobe to UART TX
o_tx_byte  out  8  byte to transmit; valid with o_tx_dv, held until next launch
o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_empty  out  1  o_count == 0
o_full  out  1  o_count == DEPTH
o_overflow  out  1  sticky: a push was dropped
i_clr_overflow  in  1  clears o_overflow and o_drop_count
o_drop_count  out  16  dropped-push counter, saturates at 16'hFFFF
o_timeout  out  1  sticky: a launch timed out; cleared by i_clr_overflow

Behaviour:
- Reset (async, reset_n_internal low), all outputs at these values:
  - o_tx_dv=0, o_tx_byte=8'h00, o_count=0, o_empty=1, o_full=0.
  - o_overflow=0, o_drop_count=0, o_timeout=0.
  - Pointers cleared; FSM in IDLE.
  - Reset mid-transfer discards queue contents. No partial state survives.
- Storage:
  - Circular buffer, DEPTH x 8.
  - Write and read pointers are $clog2(DEPTH)+1 bits wide; the extra MSB separates full from empty.
  - Pointers wrap naturally, with no special case at DEPTH-1 -> 0.
- Push:
  - i_wr_dv high and not full: byte stored, wr_ptr+1.
  - Full and no pop in the same cycle: push dropped, o_overflow<=1, o_drop_count+1 (saturating).
  - Full with a pop in the same cycle: push accepted, count unchanged.
- Pop happens only on a launch (IDLE -> WAIT_START). Simultaneous push and pop on a non-full queue leaves count unchanged.
- i_clr_overflow has priority over a simultaneous drop increment: the counter goes to 0 and the flag to 0.
- Drain FSM states:
  - IDLE: when !o_empty, !i_tx_active and no gap pending:
    - o_tx_byte<=head, o_tx_dv<=1 for exactly one clock, pop.
    - Go to WAIT_START and clear the timer.
  - WAIT_START:
    - i_tx_active=1 -> WAIT_DONE.
    - i_tx_done=1 -> GAP. This covers a UART that finishes before active is seen.
    - Timer reaches START_TIMEOUT -> o_timeout<=1, go to IDLE. The popped byte is lost and is not re-queued.
  - WAIT_DONE:
    - i_tx_done=1 -> GAP and load the gap counter with GAP_CYCLES.
    - i_tx_active falling without i_tx_done -> GAP as well (tolerant).
  - GAP: count down; at 0 (immediately when GAP_CYCLES=0) -> IDLE.
- Latency: push into an empty queue with the UART idle gives o_tx_dv high on the 2nd clock edge after the edge that samples i_wr_dv.
- Ordering: strict FIFO.
- At most one o_tx_dv per UART frame; o_tx_dv is never asserted while i_tx_active=1.
- o_count, o_empty and o_full are registered and updated on the same edge as the pointers.

Decomposition:
- Package echo_pkg holds:
  - typedef enum logic [1:0] txq_state_t {IDLE, WAIT_START, WAIT_DONE, GAP};
  - localparam HEADER_BYTE = 8'hAA;
  - default DEPTH constant.
- One sub-module, sync_fifo_8: storage, pointers, count, full/empty, with simultaneous push/pop on full.
- echo_tx_queue holds the drain FSM, timers and the drop statistics.

Test Plan:
- Single byte: push 8'h41 into an empty queue with tx idle -> o_tx_dv pulse 2 clocks later with o_tx_byte=8'h41. Model UART active for 4340 clocks, then done -> queue empty, FSM in IDLE.
- Burst: push 8'h10..8'h1F back-to-back (16 bytes, DEPTH=16) while tx is busy -> o_full=1, no drops. Output order is 10,11,…,1F, with exactly one o_tx_dv per done.
- Overflow: fill 16, push 3 more (8'hE0..E2) -> o_overflow=1, o_drop_count=3, and E0..E2 are never transmitted. Pulse i_clr_overflow -> both return to 0.
- Full with simultaneous push and pop: full queue, push 8'h77 on the launch cycle -> accepted, o_count stays 16, and 8'h77 is transmitted last.
- Timeout: push 8'h55 and hold i_tx_active=0 with no done -> after 64 clocks o_timeout=1, FSM in IDLE, next queued byte launched.
- Reset mid-operation: 5 bytes queued, in WAIT_DONE, pulse reset_n_internal low -> o_count=0, o_tx_dv=0, o_tx_byte=8'h00, state IDLE, no further launches.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and constants for the echo-path transmit queue.
// Holds the drain FSM state encoding and the default queue depth.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2,
    GAP        = 2'd3
  } txq_state_t;

  localparam logic [7:0] HEADER_BYTE       = 8'hAA;
  localparam int         TXQ_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo_8.sv
// Byte-wide circular buffer; registered count/full/empty, combinational head.
// Pushes are refused when full unless a pop lands on the same edge.
module sync_fifo_8 #(
  parameter int DEPTH = 16
) (
  input  logic                    clk_50mhz,
  input  logic                    reset_n_internal,
  input  logic                    push_i,
  input  logic [7:0]              push_dat_i,
  input  logic                    pop_i,
  output logic [7:0]              head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        empty_q, empty_d;
  logic        full_q, full_d;
  logic        push_ok;
  logic        pop_ok;

  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);

  // Extra pointer MSB distinguishes a wrapped (full) queue from an empty one.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    count_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk_50mhz or negedge reset_n_internal) begin
    if (!reset_n_internal) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = count_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/echo_tx_queue.sv
// Queues echo-path bytes and launches them one per UART frame; o_tx_dv follows
// a push into an idle empty queue by two edges. Full pushes drop unless a pop coincides.
module echo_tx_queue
  import echo_pkg::*;
#(
  parameter int DEPTH         = TXQ_DEPTH_DEFAULT,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 0
) (
  input  logic                    clk_50mhz,
  input  logic                    reset_n_internal,
  input  logic                    i_wr_dv,
  input  logic [7:0]              i_wr_byte,
  input  logic                    i_tx_active,
  input  logic                    i_tx_done,
  output logic                    o_tx_dv,
  output logic [7:0]              o_tx_byte,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_overflow,
  input  logic                    i_clr_overflow,
  output logic [15:0]             o_drop_count,
  output logic                    o_timeout
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  txq_state_t      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            launch;
  logic            launch_q;
  logic [7:0]      pend_q, pend_d;
  logic            tx_dv_q;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_q, drop_d;
  logic            timeout_q, timeout_d;
  logic            timeout_set;
  logic            drop;

  logic [7:0]             fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;

  sync_fifo_8 #(.DEPTH(DEPTH)) u_fifo (
    .clk_50mhz        (clk_50mhz),
    .reset_n_internal (reset_n_internal),
    .push_i           (i_wr_dv),
    .push_dat_i       (i_wr_byte),
    .pop_i            (launch),
    .head_o           (fifo_head),
    .count_o          (fifo_count),
    .empty_o          (fifo_empty),
    .full_o           (fifo_full)
  );

  assign drop = i_wr_dv && fifo_full && !launch;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    pend_d      = pend_q;
    launch      = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !i_tx_active) begin
          launch  = 1'b1;
          pend_d  = fifo_head;
          timer_d = '0;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (i_tx_active) begin
          state_d = WAIT_DONE;
        end else if (i_tx_done) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES);
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        // A falling busy without a done pulse still ends the frame.
        if (i_tx_done || !i_tx_active) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    timeout_d  = timeout_q;
    tx_byte_d  = launch_q ? pend_q : tx_byte_q;
    if (i_clr_overflow) begin
      overflow_d = 1'b0;
      drop_d     = '0;
      timeout_d  = 1'b0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end
      if (timeout_set) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n_internal) begin
    if (!reset_n_internal) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      gap_q      <= '0;
      pend_q     <= 8'h00;
      launch_q   <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      launch_q   <= launch;
      tx_dv_q    <= launch_q;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_tx_dv      = tx_dv_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_count      = fifo_count;
  assign o_empty      = fifo_empty;
  assign o_full       = fifo_full;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_echo_tx_queue.sv
// Scoreboard bench: accepted bytes are queued as expected launches; a monitor
// compares every o_tx_dv against the queue while a UART model answers launches.
module tb_echo_tx_queue;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n_internal;
  logic        i_wr_dv;
  logic [7:0]  i_wr_byte;
  logic        tx_active;
  logic        i_tx_done;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic [4:0]  o_count;
  logic        o_empty;
  logic        o_full;
  logic        o_overflow;
  logic        i_clr_overflow;
  logic [15:0] o_drop_count;
  logic        o_timeout;

  logic uart_busy;
  logic hold_busy;
  logic uart_mute;
  int   uart_len;

  int vectors;
  int errors;
  int dv_count;
  logic [7:0] exp_q[$];

  assign tx_active = uart_busy | hold_busy;

  echo_tx_queue #(.DEPTH(DEPTH), .START_TIMEOUT(64), .GAP_CYCLES(0)) dut (
    .clk_50mhz        (clk),
    .reset_n_internal (reset_n_internal),
    .i_wr_dv          (i_wr_dv),
    .i_wr_byte        (i_wr_byte),
    .i_tx_active      (tx_active),
    .i_tx_done        (i_tx_done),
    .o_tx_dv          (o_tx_dv),
    .o_tx_byte        (o_tx_byte),
    .o_count          (o_count),
    .o_empty          (o_empty),
    .o_full           (o_full),
    .o_overflow       (o_overflow),
    .i_clr_overflow   (i_clr_overflow),
    .o_drop_count     (o_drop_count),
    .o_timeout        (o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART stand-in: goes busy the cycle after a launch, then ends with a done pulse.
  initial begin
    uart_busy = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n_internal && o_tx_dv && !uart_mute) begin
        int len;
        len = (uart_len == 0) ? $urandom_range(2, 12) : uart_len;
        @(posedge clk); #1;
        uart_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        uart_busy = 1'b0;
        i_tx_done = 1'b1;
        @(posedge clk); #1;
        i_tx_done = 1'b0;
      end
    end
  end

  // Monitor: every launch must match the oldest accepted byte.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n_internal && o_tx_dv) begin
        dv_count++;
        check("dv_while_busy", {31'd0, tx_active}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_launch: got byte %0h, expected no launch", o_tx_byte);
        end else begin
          logic [7:0] b;
          b = exp_q.pop_front();
          check("tx_order", {24'd0, o_tx_byte}, {24'd0, b});
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit accept);
    i_wr_dv   = 1'b1;
    i_wr_byte = b;
    if (accept) exp_q.push_back(b);
    @(posedge clk); #1;
    i_wr_dv = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < 4 && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !tx_active && !i_tx_done && o_empty) quiet++;
      else quiet = 0;
    end
    check({name, "_drained"}, {31'd0, (n < max_cyc)}, 32'd1);
    check({name, "_empty"}, {31'd0, o_empty}, 32'd1);
    check({name, "_count"}, {27'd0, o_count}, 32'd0);
  endtask

  initial begin
    int n;
    int dv_before;
    vectors = 0; errors = 0; dv_count = 0;
    reset_n_internal = 1'b0;
    i_wr_dv = 1'b0; i_wr_byte = 8'h00; i_clr_overflow = 1'b0;
    hold_busy = 1'b0; uart_mute = 1'b0; uart_len = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_dv",    {31'd0, o_tx_dv}, 32'd0);
    check("rst_tx_byte",  {24'd0, o_tx_byte}, 32'd0);
    check("rst_count",    {27'd0, o_count}, 32'd0);
    check("rst_empty",    {31'd0, o_empty}, 32'd1);
    check("rst_full",     {31'd0, o_full}, 32'd0);
    check("rst_overflow", {31'd0, o_overflow}, 32'd0);
    check("rst_drops",    {16'd0, o_drop_count}, 32'd0);
    check("rst_timeout",  {31'd0, o_timeout}, 32'd0);
    reset_n_internal = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte, long frame, exact launch latency and one-cycle strobe.
    uart_len = 4340;
    push(8'h41, 1'b1);
    @(posedge clk); #1;
    check("lat_edge1_dv", {31'd0, o_tx_dv}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_dv", {31'd0, o_tx_dv}, 32'd1);
    check("lat_edge2_byte", {24'd0, o_tx_byte}, 32'h41);
    @(posedge clk); #1;
    check("dv_one_cycle", {31'd0, o_tx_dv}, 32'd0);
    wait_drain("single", 6000);
    check("byte_held", {24'd0, o_tx_byte}, 32'h41);

    // Burst to full while busy, then overflow.
    uart_len = 0;
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i), 1'b1);
    check("burst_full", {31'd0, o_full}, 32'd1);
    check("burst_count", {27'd0, o_count}, DEPTH);
    check("burst_no_ovf", {31'd0, o_overflow}, 32'd0);
    for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i), 1'b0);
    check("ovf_flag", {31'd0, o_overflow}, 32'd1);
    check("ovf_drops", {16'd0, o_drop_count}, 32'd3);
    check("ovf_count", {27'd0, o_count}, DEPTH);
    i_clr_overflow = 1'b1;
    @(posedge clk); #1;
    i_clr_overflow = 1'b0;
    check("clr_flag", {31'd0, o_overflow}, 32'd0);
    check("clr_drops", {16'd0, o_drop_count}, 32'd0);

    // Push on the launch cycle of a full queue is accepted.
    hold_busy = 1'b0;
    push(8'h77, 1'b1);
    check("fullpop_count", {27'd0, o_count}, DEPTH);
    check("fullpop_full", {31'd0, o_full}, 32'd1);
    check("fullpop_no_ovf", {31'd0, o_overflow}, 32'd0);
    wait_drain("burst", 3000);

    // Start timeout: UART never answers the first launch.
    uart_mute = 1'b1;
    push(8'h55, 1'b1);
    push(8'h66, 1'b1);
    n = 1;
    while (!o_timeout && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    uart_mute = 1'b0;
    check("timeout_latency", {31'd0, (n >= 64 && n <= 66)}, 32'd1);
    wait_drain("timeout", 500);
    check("timeout_sticky", {31'd0, o_timeout}, 32'd1);
    i_clr_overflow = 1'b1;
    @(posedge clk); #1;
    i_clr_overflow = 1'b0;
    check("timeout_clr", {31'd0, o_timeout}, 32'd0);

    // Random traffic, never enough to fill the queue.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0 && exp_q.size() < DEPTH - 2) begin
        push(8'($urandom), 1'b1);
      end else begin
        @(posedge clk); #1;
      end
    end
    wait_drain("random", 5000);
    check("random_no_drops", {16'd0, o_drop_count}, 32'd0);

    // Reset while a frame is in flight with five bytes still queued.
    uart_len = 200;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_count", {27'd0, o_count}, 32'd5);
    reset_n_internal = 1'b0;
    #2;
    check("midrst_count", {27'd0, o_count}, 32'd0);
    check("midrst_tx_dv", {31'd0, o_tx_dv}, 32'd0);
    check("midrst_tx_byte", {24'd0, o_tx_byte}, 32'd0);
    check("midrst_empty", {31'd0, o_empty}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n_internal = 1'b1;
    dv_before = dv_count;
    repeat (400) @(posedge clk);
    #1;
    check("post_reset_no_launch", dv_count, dv_before);
    check("post_reset_count", {27'd0, o_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
